// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// multi-cycle latency and serves mfhi/mflo/mthi/mtlo.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_E,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_we_q;

  logic [31:0] pend_hi_d, pend_lo_d;
  logic        pend_we_d;

  logic        is_r;
  logic [5:0]  funct;
  logic        is_mul, is_div, is_signed;
  logic        unused_instr_bits;

  assign is_r              = (Instr_E[31:26] == 6'b000000);
  assign funct             = Instr_E[5:0];
  assign is_mul            = is_r && (funct == F_MULT || funct == F_MULTU);
  assign is_div            = is_r && (funct == F_DIV  || funct == F_DIVU);
  assign is_signed         = (funct == F_MULT) || (funct == F_DIV);
  assign unused_instr_bits = &{1'b0, Instr_E[25:6]};

  assign Start = (is_mul || is_div) && (state_q == S_IDLE);
  assign Busy  = (state_q == S_BUSY);
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    MDOut = '0;
    if (is_r && funct == F_MFHI) MDOut = hi_q;
    else if (is_r && funct == F_MFLO) MDOut = lo_q;
  end

  // One multiplier serves both flavours: sign-extend only for signed mult.
  // Signed divide works on magnitudes so INT_MIN / -1 wraps naturally.
  logic [63:0] op_a, op_b, prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;

  always_comb begin
    op_a      = {{32{is_signed & RD1_E[31]}}, RD1_E};
    op_b      = {{32{is_signed & RD2_E[31]}}, RD2_E};
    prod      = op_a * op_b;
    a_mag     = (is_signed && RD1_E[31]) ? -RD1_E : RD1_E;
    b_mag     = (is_signed && RD2_E[31]) ? -RD2_E : RD2_E;
    b_safe    = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    pend_hi_d = prod[63:32];
    pend_lo_d = prod[31:0];
    pend_we_d = 1'b1;
    if (is_div) begin
      pend_lo_d = (is_signed && (RD1_E[31] ^ RD2_E[31])) ? -q_mag : q_mag;
      pend_hi_d = (is_signed && RD1_E[31]) ? -r_mag : r_mag;
      pend_we_d = (RD2_E != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
            cnt_q     <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
            state_q   <= S_BUSY;
          end else if (is_r && funct == F_MTHI) begin
            hi_q <= RD1_E;
          end else if (is_r && funct == F_MTLO) begin
            lo_q <= RD1_E;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            if (pend_we_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic model of HI/LO.
module tb_mult_div_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr_E = '0, RD1_E = '0, RD2_E = '0;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDOut;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Instr_E(Instr_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] f);
    return {6'b000000, 20'($urandom), f};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    Instr_E = ins;
    RD1_E   = a;
    RD2_E   = b;
    #1;
  endtask

  // Reference: 64-bit arithmetic; SV integer division truncates toward zero.
  task automatic model_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT:  begin p = 64'(sa * sb); {hi_m, lo_m} = p; end
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = p; end
      F_DIV:   if (b != 0) begin
                 sq = sa / sb; sr = sa % sb;
                 lo_m = sq[31:0]; hi_m = sr[31:0];
               end
      F_DIVU:  if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      default: ;
    endcase
  endtask

  task automatic run_md(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    int n, cnt;
    n = (f == F_DIV || f == F_DIVU) ? 10 : 5;
    drive(mk(f), a, b);
    chk({tag, "_start"}, 32'(Start), 32'd1);
    tick();
    drive(32'h0, $urandom, $urandom);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
      if (cnt == 2) drive(mk(F_ADD), $urandom, $urandom);
      if (cnt == 3) drive(32'h0, $urandom, $urandom);
    end
    chk({tag, "_busylen"}, 32'(cnt), 32'(n));
    model_md(f, a, b);
    chk({tag, "_hi"}, HI, hi_m);
    chk({tag, "_lo"}, LO, lo_m);
  endtask

  initial begin
    int          cnt;
    logic        busy_seen;
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [5:0]  fl [9] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_ADD};

    // Reset
    drive(32'h0, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_start", 32'(Start), 32'd0);

    // mthi then mflo
    drive(mk(F_MTHI), 32'h12345678, 32'h0);
    tick();
    hi_m = 32'h12345678;
    drive(mk(F_MFLO), 32'h0, 32'h0);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo", LO, 32'h0);
    chk("mflo_out", MDOut, 32'h0);
    drive(mk(F_MFHI), 32'h0, 32'h0);
    chk("mfhi_out", MDOut, 32'h12345678);
    tick();

    // Directed arithmetic
    run_md("mult", F_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi_c", HI, 32'hFFFFFFFF);
    chk("mult_lo_c", LO, 32'hFFFFFFFA);
    run_md("multu", F_MULTU, 32'hFFFFFFFE, 32'd3);
    chk("multu_hi_c", HI, 32'h00000002);
    chk("multu_lo_c", LO, 32'hFFFFFFFA);
    run_md("div", F_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_lo_c", LO, 32'hFFFFFFFD);
    chk("div_hi_c", HI, 32'hFFFFFFFF);
    drive(mk(F_MFLO), 32'h0, 32'h0);
    chk("div_mflo", MDOut, 32'hFFFFFFFD);
    tick();

    // Divide by zero leaves HI/LO untouched
    drive(mk(F_MTHI), 32'hAA, 32'h0); tick(); hi_m = 32'hAA;
    drive(mk(F_MTLO), 32'hBB, 32'h0); tick(); lo_m = 32'hBB;
    run_md("div0", F_DIV, 32'h1234, 32'h0);
    chk("div0_hi_c", HI, 32'hAA);
    chk("div0_lo_c", LO, 32'hBB);
    run_md("divu0", F_DIVU, 32'hFFFF0000, 32'h0);

    // Signed overflow case
    run_md("ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_lo_c", LO, 32'h80000000);
    chk("ovf_hi_c", HI, 32'h0);

    // mult and mtlo issued while busy are ignored
    drive(mk(F_MULT), 32'd7, 32'd9);
    chk("bz_start", 32'(Start), 32'd1);
    tick();
    cnt = 0;
    drive(mk(F_MULT), 32'd3, 32'd4);
    chk("bz_restart_start", 32'(Start), 32'd0);
    if (Busy === 1'b1) cnt++;
    tick();
    drive(mk(F_MTLO), 32'h55, 32'h0);
    if (Busy === 1'b1) cnt++;
    tick();
    drive(mk(F_MTHI), 32'h66, 32'h0);
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("bz_busylen", 32'(cnt), 32'd5);
    chk("bz_lo", LO, 32'd63);
    chk("bz_hi", HI, 32'd0);
    hi_m = 32'd0; lo_m = 32'd63;
    drive(32'h0, 32'h0, 32'h0);
    tick();

    // Reset in the 3rd busy cycle of a div aborts it
    drive(mk(F_MTHI), 32'h11, 32'h0); tick();
    drive(mk(F_MTLO), 32'h22, 32'h0); tick();
    drive(mk(F_DIV), 32'd100, 32'd7);
    tick();
    drive(32'h0, 32'h0, 32'h0);
    tick(); tick();
    chk("ra_busy3", 32'(Busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ra_busy", 32'(Busy), 32'd0);
    chk("ra_hi", HI, 32'h0);
    chk("ra_lo", LO, 32'h0);
    hi_m = '0; lo_m = '0;
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Busy !== 1'b0) busy_seen = 1'b1;
    end
    chk("ra_nobusy", 32'(busy_seen), 32'd0);
    chk("ra_late_hi", HI, 32'h0);
    chk("ra_late_lo", LO, 32'h0);
    run_md("ra_mult", F_MULT, 32'h00010003, 32'hFFFFFFF0);

    // Randomized instruction mix
    for (int i = 0; i < 60; i++) begin
      f = fl[$urandom_range(0, 8)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      case (f)
        F_MULT, F_MULTU, F_DIV, F_DIVU: run_md("rnd_md", f, a, b);
        F_MTHI: begin drive(mk(f), a, b); tick(); hi_m = a; chk("rnd_mthi", HI, hi_m); end
        F_MTLO: begin drive(mk(f), a, b); tick(); lo_m = a; chk("rnd_mtlo", LO, lo_m); end
        F_MFHI: begin drive(mk(f), a, b); chk("rnd_mfhi", MDOut, hi_m); tick(); end
        F_MFLO: begin drive(mk(f), a, b); chk("rnd_mflo", MDOut, lo_m); tick(); end
        default: begin
          drive(mk(f), a, b);
          chk("rnd_nop_out", MDOut, 32'h0);
          chk("rnd_nop_start", 32'(Start), 32'd0);
          tick();
          chk("rnd_nop_hi", HI, hi_m);
          chk("rnd_nop_lo", LO, lo_m);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
